// File: rtl/pipelined_compressor_multiplier.sv
// Three-stage valid/ready multiplier: S1 operand capture, S2 carry-save rows from a
// 5:2-compressor tree over (optionally Baugh-Wooley) partial products, S3 final add.
module pipelined_compressor_multiplier #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned NROWS = WIDTH + 1;
  localparam int unsigned LVLS  = 8;

  logic             s1_valid_q, s1_valid_d;
  logic             s1_sgn_q,   s1_sgn_d;
  logic [WIDTH-1:0] s1_a_q,     s1_a_d;
  logic [WIDTH-1:0] s1_b_q,     s1_b_d;
  logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

  logic             s2_valid_q, s2_valid_d;
  logic [PW-1:0]    s2_sum_q,   s2_sum_d;
  logic [PW-1:0]    s2_carry_q, s2_carry_d;
  logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;

  logic             s3_valid_q, s3_valid_d;
  logic [PW-1:0]    s3_p_q,     s3_p_d;
  logic [TAG_W-1:0] s3_tag_q,   s3_tag_d;

  logic             advance;
  logic [PW-1:0]    tree_sum, tree_carry;

  logic [PW-1:0]    rows [NROWS];
  logic [PW-1:0]    nxt  [NROWS];
  logic [WIDTH-1:0] pp;
  logic [PW-1:0]    t1, t2, c1, c2;
  int unsigned      n, m, i;

  function automatic logic [PW-1:0] maj(input logic [PW-1:0] x, input logic [PW-1:0] y,
                                        input logic [PW-1:0] z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Row-wise 5:2 compressor: the two intermediate carries shifted left one column are the
  // carry-ins of the neighbouring compressor, so each 5-row group collapses to 2 rows.
  always_comb begin
    pp = '0;
    t1 = '0;
    t2 = '0;
    c1 = '0;
    c2 = '0;
    for (int unsigned r = 0; r < WIDTH; r++) begin
      pp = s1_a_q & {WIDTH{s1_b_q[r]}};
      if (s1_sgn_q) begin
        if (r < WIDTH - 1) pp[WIDTH-1]   = ~pp[WIDTH-1];
        else               pp[WIDTH-2:0] = ~pp[WIDTH-2:0];
      end
      rows[r] = PW'(pp) << r;
    end
    rows[WIDTH] = s1_sgn_q ? ((PW'(1) << WIDTH) | (PW'(1) << (PW - 1))) : '0;
    n = NROWS;
    for (int unsigned lvl = 0; lvl < LVLS; lvl++) begin
      nxt = '{default: '0};
      m = 0;
      i = 0;
      for (int unsigned g = 0; g < NROWS; g++) begin
        if (n > 2 && i + 5 <= n) begin
          t1 = rows[i] ^ rows[i+1] ^ rows[i+2];
          c1 = maj(rows[i], rows[i+1], rows[i+2]) << 1;
          t2 = t1 ^ rows[i+3] ^ rows[i+4];
          c2 = maj(t1, rows[i+3], rows[i+4]) << 1;
          nxt[m]   = t2 ^ c1 ^ c2;
          nxt[m+1] = maj(t2, c1, c2) << 1;
          i = i + 5;
          m = m + 2;
        end else if (n > 2 && i + 3 <= n) begin
          nxt[m]   = rows[i] ^ rows[i+1] ^ rows[i+2];
          nxt[m+1] = maj(rows[i], rows[i+1], rows[i+2]) << 1;
          i = i + 3;
          m = m + 2;
        end else if (i < n) begin
          nxt[m] = rows[i];
          i = i + 1;
          m = m + 1;
        end
      end
      rows = nxt;
      n = m;
    end
    tree_sum   = rows[0];
    tree_carry = rows[1];
  end

  always_comb begin
    advance    = ~s3_valid_q | out_ready;
    s1_valid_d = s1_valid_q;
    s1_sgn_d   = s1_sgn_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    s2_sum_d   = s2_sum_q;
    s2_carry_d = s2_carry_q;
    s2_tag_d   = s2_tag_q;
    s3_valid_d = s3_valid_q;
    s3_p_d     = s3_p_q;
    s3_tag_d   = s3_tag_q;
    if (advance) begin
      s1_valid_d = in_valid;
      s2_valid_d = s1_valid_q;
      s3_valid_d = s2_valid_q;
      // Data only moves behind a valid bit, so idle operand buses never reach out_p.
      if (in_valid) begin
        s1_sgn_d = in_signed;
        s1_a_d   = in_a;
        s1_b_d   = in_b;
        s1_tag_d = in_tag;
      end
      if (s1_valid_q) begin
        s2_sum_d   = tree_sum;
        s2_carry_d = tree_carry;
        s2_tag_d   = s1_tag_q;
      end
      if (s2_valid_q) begin
        s3_p_d   = s2_sum_q + s2_carry_q;
        s3_tag_d = s2_tag_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s3_p_q     <= '0;
      s3_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sgn_q   <= s1_sgn_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_sum_q   <= s2_sum_d;
      s2_carry_q <= s2_carry_d;
      s2_tag_q   <= s2_tag_d;
      s3_valid_q <= s3_valid_d;
      s3_p_q     <= s3_p_d;
      s3_tag_q   <= s3_tag_d;
    end
  end

  assign in_ready  = advance;
  assign out_valid = s3_valid_q;
  assign out_p     = s3_p_q;
  assign out_tag   = s3_tag_q;
  assign busy      = s1_valid_q | s2_valid_q | s3_valid_q;

endmodule

// File: tb/tb_pipelined_compressor_multiplier.sv
// Bench for pipelined_compressor_multiplier: WIDTH=8 and WIDTH=16 instances checked
// against an arithmetic product model through an in-order expected-result queue.
`timescale 1ns/1ps
module tb_pipelined_compressor_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_signed = 1'b0, out_ready = 1'b0;
  logic [7:0]  in_a = '0, in_b = '0;
  logic [3:0]  in_tag = '0;
  logic        in_ready, out_valid, busy;
  logic [15:0] out_p;
  logic [3:0]  out_tag;

  logic        in_valid_w = 1'b0, in_signed_w = 1'b0, out_ready_w = 1'b1;
  logic [15:0] in_a_w = '0, in_b_w = '0;
  logic [3:0]  in_tag_w = '0;
  logic        in_ready_w, out_valid_w, busy_w;
  logic [31:0] out_p_w;
  logic [3:0]  out_tag_w;

  pipelined_compressor_multiplier #(.WIDTH(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_tag(out_tag), .busy(busy)
  );

  pipelined_compressor_multiplier #(.WIDTH(16), .TAG_W(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w), .in_signed(in_signed_w),
    .in_a(in_a_w), .in_b(in_b_w), .in_tag(in_tag_w), .out_valid(out_valid_w),
    .out_ready(out_ready_w), .out_p(out_p_w), .out_tag(out_tag_w), .busy(busy_w)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] p; logic [3:0] tag; } exp8_t;
  typedef struct { logic [31:0] p; logic [3:0] tag; } exp16_t;

  exp8_t       q8[$];
  exp16_t      q16[$];
  int unsigned n_cmp = 0, n_err = 0;
  int unsigned delivered = 0;
  bit          hold_pend = 1'b0;
  logic [15:0] held_p;
  logic [3:0]  held_tag;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref8(input bit sg, input logic [7:0] a, input logic [7:0] b);
    longint x, y;
    x = sg ? longint'($signed(a)) : longint'(a);
    y = sg ? longint'($signed(b)) : longint'(b);
    return 16'(x * y);
  endfunction

  function automatic logic [31:0] ref16(input bit sg, input logic [15:0] a, input logic [15:0] b);
    longint x, y;
    x = sg ? longint'($signed(a)) : longint'(a);
    y = sg ? longint'($signed(b)) : longint'(b);
    return 32'(x * y);
  endfunction

  task automatic step8(input bit rs, input bit iv, input bit sg, input logic [7:0] a,
                       input logic [7:0] b, input logic [3:0] tg, input bit ordy, output bit acc);
    exp8_t e;
    @(negedge clk);
    rst = rs; in_valid = iv; in_signed = sg; in_a = a; in_b = b; in_tag = tg; out_ready = ordy;
    #1;
    acc = 1'b0;
    if (rs) begin
      q8.delete();
      hold_pend = 1'b0;
      return;
    end
    check("in_ready_rule", in_ready, !out_valid || ordy);
    if (hold_pend) begin
      check("hold_valid", out_valid, 1);
      check("hold_p", out_p, held_p);
      check("hold_tag", out_tag, held_tag);
    end
    if (out_valid && ordy) begin
      delivered++;
      if (q8.size() == 0) check("spurious_out", out_valid, 0);
      else begin
        e = q8.pop_front();
        check("prod8", out_p, e.p);
        check("tag8", out_tag, e.tag);
      end
    end
    hold_pend = out_valid && !ordy;
    held_p = out_p;
    held_tag = out_tag;
    if (iv && in_ready) begin
      acc = 1'b1;
      q8.push_back(exp8_t'{ref8(sg, a, b), tg});
    end
  endtask

  task automatic step16(input bit iv, input bit sg, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] tg);
    exp16_t e;
    @(negedge clk);
    rst = 1'b0; in_valid_w = iv; in_signed_w = sg; in_a_w = a; in_b_w = b; in_tag_w = tg;
    out_ready_w = 1'b1;
    #1;
    if (out_valid_w) begin
      if (q16.size() == 0) check("spurious_out16", out_valid_w, 0);
      else begin
        e = q16.pop_front();
        check("prod16", out_p_w, e.p);
        check("tag16", out_tag_w, e.tag);
      end
    end
    if (iv && in_ready_w) q16.push_back(exp16_t'{ref16(sg, a, b), tg});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit          acc;
    int unsigned d0, j;
    logic [7:0]  sa [5];
    logic [7:0]  sb [5];
    logic [7:0]  ea, eb;
    logic [15:0] sexp [3];
    logic [7:0]  edge_vals [4];

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_p", out_p, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_p16", out_p_w, 0);

    // WIDTH=16 directed then random
    step16(1, 0, 16'hFFFF, 16'hFFFF, 4'h3);
    step16(1, 1, 16'h8000, 16'hFFFF, 4'h4);
    for (int k = 1; k <= 3; k++) begin
      step16(0, 0, '0, '0, '0);
      if (k == 2) check("w16_unsigned", out_p_w, 32'hFFFE0001);
      if (k == 3) check("w16_signed", out_p_w, 32'h00008000);
    end
    for (int k = 0; k < 300; k++)
      step16($urandom_range(0, 3) != 0, 1'($urandom), 16'($urandom), 16'($urandom),
             4'($urandom));
    for (int k = 0; k < 5; k++) step16(0, 0, '0, '0, '0);
    check("w16_drained", q16.size(), 0);

    // WIDTH=8 latency and value
    step8(0, 1, 0, 8'hFF, 8'hFF, 4'h5, 1, acc);
    for (int k = 1; k <= 3; k++) begin
      step8(0, 0, 0, '0, '0, '0, 1, acc);
      if (k < 3) check("lat_not_yet", out_valid, 0);
      else begin
        check("lat_valid", out_valid, 1);
        check("ff_x_ff", out_p, 16'hFE01);
        check("ff_tag", out_tag, 4'h5);
      end
    end

    // signed back-to-back
    sexp[0] = 16'h4000; sexp[1] = 16'hFF81; sexp[2] = 16'hFF80;
    step8(0, 1, 1, 8'h80, 8'h80, 4'h1, 1, acc);
    step8(0, 1, 1, 8'hFF, 8'h7F, 4'h2, 1, acc);
    step8(0, 1, 1, 8'h80, 8'h01, 4'h3, 1, acc);
    for (int k = 0; k < 3; k++) begin
      step8(0, 0, 0, '0, '0, '0, 1, acc);
      check("signed_valid", out_valid, 1);
      check("signed_p", out_p, sexp[k]);
      check("signed_tag", out_tag, 4'(k + 1));
    end

    // stall
    for (int k = 0; k < 5; k++) begin
      sa[k] = 8'($urandom);
      sb[k] = 8'($urandom);
    end
    d0 = delivered;
    j = 0;
    for (int c = 0; c < 40 && (j < 5 || q8.size() != 0); c++) begin
      ea = (j < 5) ? sa[j] : 8'h00;
      eb = (j < 5) ? sb[j] : 8'h00;
      step8(0, j < 5, 0, ea, eb, 4'(j + 8), !(c >= 2 && c < 6), acc);
      if (acc) j++;
      if (c >= 3 && c < 6) check("stall_in_ready", in_ready, 0);
    end
    check("stall_delivered", delivered - d0, 5);
    check("stall_drained", q8.size(), 0);

    // reset mid-flight, rst also overriding a presented transaction
    step8(0, 1, 0, 8'h12, 8'h34, 4'hA, 1, acc);
    step8(0, 1, 1, 8'h56, 8'h78, 4'hB, 1, acc);
    step8(1, 1, 0, 8'h9A, 8'hBC, 4'hC, 1, acc);
    step8(0, 0, 0, '0, '0, '0, 1, acc);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    for (int k = 0; k < 5; k++) begin
      step8(0, 0, 0, '0, '0, '0, 1, acc);
      check("midrst_no_result", out_valid, 0);
    end

    // random traffic with backpressure and rare resets
    edge_vals[0] = 8'h00; edge_vals[1] = 8'h7F; edge_vals[2] = 8'h80; edge_vals[3] = 8'hFF;
    for (int k = 0; k < 10000; k++) begin
      ea = ($urandom_range(0, 4) == 0) ? edge_vals[$urandom_range(0, 3)] : 8'($urandom);
      eb = ($urandom_range(0, 4) == 0) ? edge_vals[$urandom_range(0, 3)] : 8'($urandom);
      step8($urandom_range(0, 999) == 0, $urandom_range(0, 3) != 0, 1'($urandom), ea, eb,
            4'($urandom), $urandom_range(0, 3) != 0, acc);
    end
    for (int k = 0; k < 20; k++) step8(0, 0, 0, '0, '0, '0, 1, acc);
    check("rand_drained", q8.size(), 0);
    check("rand_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipelined_compressor_multiplier.md
Name: pipelined_compressor_multiplier

Overview:
- Parametrised, pipelined Wallace-tree multiplier. Supports WIDTH x WIDTH operands in unsigned or signed (two's complement) mode, selected per transaction.
- Partial products are reduced with 5:2 compressors plus full/half adders. Pipeline registers are inserted after partial-product reduction and after the final carry-propagate add.
- Sits between operand-issue logic and the datapath result bus. Uses valid/ready handshakes on both sides so that downstream backpressure stalls the pipeline without loss.

Parameters:
- WIDTH, 8, operand width in bits. Legal range 4..32. The product is 2*WIDTH bits.
- TAG_W, 4, width of the opaque transaction tag carried alongside each operand pair.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair and mode present.
- in_ready  out  1  block accepts operands this cycle.
- in_signed  in  1  1 = signed (two's complement) multiply, 0 = unsigned.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- in_tag  in  TAG_W  opaque tag, returned unchanged with the result.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts the product.
- out_p  out  2*WIDTH  product.
- out_tag  out  TAG_W  tag of the transaction in out_p.
- busy  out  1  at least one pipeline stage holds a valid transaction.

Behaviour:
- Single clock. Reset is synchronous and active-high: clk/rst, sampled on the rising edge of clk.
- Three register stages: S1, S2, S3. Each stage holds a valid bit, tag and data.
  - S1 registers inputs: a, b, signed flag, tag.
  - S1 -> S2: combinational partial-product generation and tree reduction to two 2*WIDTH rows (sum, carry); the rows are registered in S2.
  - S2 -> S3: the carry-propagate add of the two rows; the result is registered in S3, which drives out_*.
- Latency: a transaction accepted in cycle N appears with out_valid=1 in cycle N+3, provided there is no stall. Throughput is one transaction per cycle.
- Partial products:
  - Unsigned: pp[i] = a & {WIDTH{b[i]}}.
  - Signed: Baugh-Wooley form. Invert the MSB bit of every row except the last. In the last row, invert all bits except the MSB. Add the constant 1 at columns WIDTH and 2*WIDTH-1.
  - The result is the exact 2*WIDTH-bit product, modulo 2^(2*WIDTH). There is no overflow or saturation.
- Handshake:
  - advance = ~out_valid | out_ready.
  - When advance=1, all stages shift together: S3 <- S2, S2 <- S1, S1 <- input (valid = in_valid & in_ready).
  - When advance=0, all stages hold.
  - in_ready = advance. It is combinational from out_valid and out_ready and does not depend on in_valid.
  - An input transfer occurs when in_valid & in_ready. An output transfer occurs when out_valid & out_ready.
  - Bubbles (valid=0) propagate as bubbles. The pipeline does not compact them.
  - out_p and out_tag stay stable while out_valid=1 and out_ready=0.
- busy = S1.valid | S2.valid | S3.valid.
- Simultaneous events:
  - An output transfer and an input transfer in the same cycle are both honoured, with no lost or duplicated transaction.
  - in_signed is captured per transaction. Mixing signed and unsigned back-to-back is legal.
- Reset:
  - All valid bits clear to 0. out_valid=0, busy=0, out_p=0, out_tag=0.
  - After reset, in_ready=1 (because out_valid=0).
  - Reset mid-operation discards every in-flight transaction. No result from before reset may appear after it.
  - rst dominates in_valid in the same cycle.
- X-safety: data registers load only when their stage advances. Operand values on in_a/in_b are don't-care when in_valid=0 and must not affect out_p.

Test Plan:
- WIDTH=8, unsigned, a=0xFF, b=0xFF, out_ready=1 -> out_valid 3 cycles later, out_p=0xFE01, out_tag echoes the input tag.
- WIDTH=8, signed pairs back-to-back with tags 1,2,3:
  - (0x80,0x80) -> 0x4000
  - (0xFF,0x7F) -> 0xFF81
  - (0x80,0x01) -> 0xFF80
  - Results arrive on 3 consecutive cycles, in order.
- Stall: stream 5 unsigned products with out_ready held 0 from cycle 2 for 4 cycles. Required: in_ready=0 while stalled, out_p held stable, all 5 results delivered in order with correct values, none dropped or duplicated.
- Reset mid-flight: accept 2 transactions, assert rst for 1 cycle. Required: out_valid=0 and busy=0 the next cycle, and neither result ever appears.
- WIDTH=16: unsigned 0xFFFF*0xFFFF=0xFFFE0001; signed 0x8000*0xFFFF=0x00008000.
- Random: 10k random a/b/mode/out_ready patterns against a behavioural reference model; zero mismatches.
